// File: rtl/cache_controller_pkg.sv
// Shared constants for the data-cache controller: FSM encoding, data-memory base
// address, cache geometry and the byte-address to cache-address mapping.
package cache_controller_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_MISS = 2'd1;
  localparam logic [1:0] S_FILL_DONE = 2'd2;
  localparam logic [1:0] S_WRITE     = 2'd3;

  localparam logic [31:0] BASE_ADDR = 32'd1024;

  localparam int TAG_W    = 11;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 1;
  localparam int LINE_W   = 64;
  localparam int CADDR_W  = TAG_W + INDEX_W + OFFSET_W;

  // Word address relative to the memory base; wraps modulo 2^32 on purpose.
  function automatic logic [CADDR_W-1:0] map_addr(input logic [31:0] addr,
                                                  input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[CADDR_W+1:2];
  endfunction

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_controller.sv
// Sequences the 2-way data cache between the MEM stage and the SRAM controller:
// read-allocate loads, write-through no-allocate stores, hit/miss statistics.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = cache_controller_pkg::BASE_ADDR,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [CADDR_W-1:0]  cache_address,
  output logic [LINE_W-1:0]   cache_wdata,
  output logic                cache_writeEn,
  output logic                cache_invalidate,
  output logic                cache_LRU_update,
  input  logic [31:0]         cache_rdata,
  input  logic                cache_hit,
  output logic                sram_r_en,
  output logic                sram_w_en,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  input  logic [LINE_W-1:0]   sram_rdata,
  input  logic                sram_ready,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       hit_inc;
  logic       miss_inc;

  assign cache_address = map_addr(address, BASE_ADDR);
  assign cache_wdata   = sram_rdata;
  assign sram_address  = address;
  assign sram_wdata    = wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ready            = 1'b0;
    rdata            = '0;
    cache_writeEn    = 1'b0;
    cache_invalidate = 1'b0;
    cache_LRU_update = 1'b0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Stores win over loads when both enables are raised together.
        if (MEM_W_EN) begin
          cache_invalidate = cache_hit;
          state_next       = S_WRITE;
        end else if (MEM_R_EN) begin
          if (cache_hit) begin
            ready            = 1'b1;
            rdata            = cache_rdata;
            cache_LRU_update = 1'b1;
            hit_inc          = 1'b1;
          end else begin
            miss_inc   = 1'b1;
            state_next = S_READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_READ_MISS: begin
        sram_r_en = 1'b1;
        if (sram_ready) begin
          cache_writeEn = 1'b1;
          state_next    = S_FILL_DONE;
        end
      end
      S_FILL_DONE: begin
        // The freshly filled line now hits, so the cache supplies the word.
        ready            = 1'b1;
        rdata            = cache_rdata;
        cache_LRU_update = 1'b1;
        state_next       = S_IDLE;
      end
      S_WRITE: begin
        sram_w_en = 1'b1;
        if (sram_ready) begin
          ready      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache and SRAM around the DUT, a
// transaction-level timeline model, and a per-cycle compare process.
module tb_cache_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] cache_address;
  logic [63:0] cache_wdata;
  logic        cache_writeEn, cache_invalidate, cache_LRU_update;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count, miss_count;

  logic [31:0] d2_rdata;
  logic        d2_ready;
  logic [17:0] d2_caddr;
  logic [63:0] d2_cwdata;
  logic        d2_we, d2_inv, d2_lru, d2_sr, d2_sw;
  logic [31:0] d2_saddr, d2_swdata;
  logic [1:0]  d2_hit_count, d2_miss_count;

  cache_controller #(.BASE_ADDR(32'd1024), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_wdata(cache_wdata),
    .cache_writeEn(cache_writeEn), .cache_invalidate(cache_invalidate),
    .cache_LRU_update(cache_LRU_update), .cache_rdata(cache_rdata),
    .cache_hit(cache_hit), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation checks.
  cache_controller #(.BASE_ADDR(32'd1024), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .address(address), .wdata(wdata), .rdata(d2_rdata), .ready(d2_ready),
    .cache_address(d2_caddr), .cache_wdata(d2_cwdata),
    .cache_writeEn(d2_we), .cache_invalidate(d2_inv),
    .cache_LRU_update(d2_lru), .cache_rdata(cache_rdata),
    .cache_hit(cache_hit), .sram_r_en(d2_sr), .sram_w_en(d2_sw),
    .sram_address(d2_saddr), .sram_wdata(d2_swdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(d2_hit_count), .miss_count(d2_miss_count)
  );

  // ---------------- behavioural 2-way cache ----------------
  logic        cache_clr;
  logic        cv   [2][64];
  logic [10:0] ctg  [2][64];
  logic [63:0] cdat [2][64];
  logic        clru [64];
  logic [5:0]  c_idx;
  logic [10:0] c_tag;
  logic        h0, h1, lway;
  logic [63:0] c_line;

  assign c_idx       = cache_address[6:1];
  assign c_tag       = cache_address[17:7];
  assign h0          = cv[0][c_idx] && (ctg[0][c_idx] == c_tag);
  assign h1          = cv[1][c_idx] && (ctg[1][c_idx] == c_tag);
  assign cache_hit   = h0 | h1;
  assign c_line      = h1 ? cdat[1][c_idx] : cdat[0][c_idx];
  assign cache_rdata = cache_address[0] ? c_line[63:32] : c_line[31:0];
  assign lway        = clru[c_idx];

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 64; i++) begin
        cv[0][i] <= 1'b0;
        cv[1][i] <= 1'b0;
        clru[i]  <= 1'b0;
      end
    end else if (cache_writeEn) begin
      cv[lway][c_idx]   <= 1'b1;
      ctg[lway][c_idx]  <= c_tag;
      cdat[lway][c_idx] <= cache_wdata;
      clru[c_idx]       <= ~lway;
    end else if (cache_invalidate && cache_hit) begin
      cv[h1][c_idx] <= 1'b0;
    end else if (cache_LRU_update && cache_hit) begin
      clru[c_idx] <= ~h1;
    end
  end

  // ---------------- behavioural SRAM ----------------
  logic [63:0] env_mem [16];
  logic [31:0] s_off;
  int          sram_lat;
  int          sram_cnt;
  assign s_off      = sram_address - 32'd1024;
  assign sram_rdata = env_mem[s_off[6:3]];

  always @(posedge clk) begin
    if (!rst) begin
      sram_cnt   <= 0;
      sram_ready <= 1'b0;
    end else if ((sram_r_en || sram_w_en) && !sram_ready) begin
      if (sram_cnt == sram_lat - 2) begin
        sram_ready <= 1'b1;
        sram_cnt   <= 0;
      end else begin
        sram_cnt <= sram_cnt + 1;
      end
    end else begin
      sram_ready <= 1'b0;
      sram_cnt   <= 0;
    end
  end

  // ---------------- model ----------------
  typedef struct {
    logic        rdy;
    logic [31:0] rd;
    logic        we, inv, lru, sr, sw;
    logic [63:0] wline;
    logic [17:0] caddr;
    logic [31:0] saddr, swdata;
    int          hits, misses;
  } exp_t;

  exp_t        q[$];
  logic [63:0] exp_mem [16];
  bit          resident [16];
  int          m_hits, m_misses;
  logic [31:0] cur_addr, cur_wdata;
  int          n_cmp, n_fail;
  bit          check_en;
  logic [31:0] last_rd;

  function automatic logic [63:0] init_line(input int k);
    if (k == 0) return 64'hAAAA_BBBB_1111_2222;
    return {16'hD00D, 12'h000, 4'(k), 16'hC00C, 12'h000, 4'(k)};
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic mk(input logic r, input logic [31:0] d, input logic we,
                    input logic inv, input logic lru, input logic sr, input logic sw);
    exp_t e;
    logic [31:0] off;
    off      = cur_addr - 32'd1024;
    e.rdy    = r;
    e.rd     = d;
    e.we     = we;
    e.inv    = inv;
    e.lru    = lru;
    e.sr     = sr;
    e.sw     = sw;
    e.wline  = exp_mem[off[6:3]];
    e.caddr  = off[19:2];
    e.saddr  = cur_addr;
    e.swdata = cur_wdata;
    e.hits   = m_hits;
    e.misses = m_misses;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (check_en && q.size() > 0) begin
        e = q.pop_front();
        chk("ready",     64'(ready),            64'(e.rdy));
        chk("rdata",     64'(rdata),            64'(e.rd));
        chk("writeEn",   64'(cache_writeEn),    64'(e.we));
        chk("invalidate",64'(cache_invalidate), 64'(e.inv));
        chk("lru_update",64'(cache_LRU_update), 64'(e.lru));
        chk("sram_r_en", 64'(sram_r_en),        64'(e.sr));
        chk("sram_w_en", 64'(sram_w_en),        64'(e.sw));
        chk("cache_addr",64'(cache_address),    64'(e.caddr));
        chk("sram_addr", 64'(sram_address),     64'(e.saddr));
        chk("sram_wdata",64'(sram_wdata),       64'(e.swdata));
        chk("hit_count", 64'(hit_count),        64'(sat16(e.hits)));
        chk("miss_count",64'(miss_count),       64'(sat16(e.misses)));
        chk("hit2",      64'(d2_hit_count),     64'(sat2(e.hits)));
        chk("miss2",     64'(d2_miss_count),    64'(sat2(e.misses)));
        if (e.we) chk("cache_wdata", cache_wdata, e.wline);
        if (e.rdy && e.lru) last_rd = rdata;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    cur_addr  = address;
    cur_wdata = wdata;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    for (int i = 0; i < n; i++) mk(1'b1, 32'h0, 0, 0, 0, 0, 0);
    run(n);
  endtask

  task automatic rd(input logic [31:0] a, input int lat);
    logic [31:0] off, word;
    int k, n0;
    n0        = q.size();
    cur_addr  = a;
    cur_wdata = wdata;
    sram_lat  = lat;
    off       = a - 32'd1024;
    k         = int'(off[6:3]);
    word      = off[2] ? exp_mem[k][63:32] : exp_mem[k][31:0];
    if (resident[k]) begin
      mk(1'b1, word, 0, 0, 1, 0, 0);
      m_hits = sat16(m_hits + 1);
    end else begin
      mk(1'b0, 32'h0, 0, 0, 0, 0, 0);
      m_misses = sat16(m_misses + 1);
      for (int i = 1; i <= lat; i++) mk(1'b0, 32'h0, (i == lat), 0, 0, 1, 0);
      mk(1'b1, word, 0, 0, 1, 0, 0);
      resident[k] = 1'b1;
    end
    $display("read  addr=%h lat=%0d expect=%h cycles=%0d", a, lat, word, q.size() - n0);
    address  = a;
    mem_r_en = 1'b1;
    mem_w_en = 1'b0;
    run(q.size() - n0);
    mem_r_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat,
                    input logic both);
    logic [31:0] off;
    int k, n0;
    n0        = q.size();
    cur_addr  = a;
    cur_wdata = d;
    sram_lat  = lat;
    off       = a - 32'd1024;
    k         = int'(off[6:3]);
    mk(1'b0, 32'h0, 0, resident[k], 0, 0, 0);
    resident[k] = 1'b0;
    for (int i = 1; i <= lat; i++) mk((i == lat), 32'h0, 0, 0, 0, 0, 1);
    if (off[2]) exp_mem[k][63:32] = d; else exp_mem[k][31:0] = d;
    env_mem[k] = exp_mem[k];
    $display("write addr=%h data=%h lat=%0d both=%0d cycles=%0d", a, d, lat, both, q.size() - n0);
    address  = a;
    wdata    = d;
    mem_w_en = 1'b1;
    mem_r_en = both;
    run(q.size() - n0);
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    check_en  = 1'b0;
    last_rd   = 32'h0;
    m_hits    = 0;
    m_misses  = 0;
    sram_lat  = 4;
    rst       = 1'b0;
    cache_clr = 1'b1;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    address   = 32'd1024;
    wdata     = 32'h0;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i]  = init_line(i);
      env_mem[i]  = init_line(i);
      resident[i] = 1'b0;
    end
    run(2);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_hits",  64'(hit_count), 64'd0);
    chk("rst_sr",    64'(sram_r_en | sram_w_en), 64'd0);
    rst       = 1'b1;
    cache_clr = 1'b0;
    check_en  = 1'b1;
    idle(2);

    rd(32'd1024, 4);
    chk("cold_rdata", 64'(last_rd), 64'h1111_2222);
    chk("cold_miss",  64'(miss_count), 64'd1);
    rd(32'd1028, 4);
    chk("hit_rdata",  64'(last_rd), 64'hAAAA_BBBB);
    chk("hit_count1", 64'(hit_count), 64'd1);
    wr(32'd1024, 32'h55, 4, 1'b0);
    rd(32'd1024, 4);
    chk("refill_rdata", 64'(last_rd), 64'h55);
    chk("miss_count2",  64'(miss_count), 64'd2);
    wr(32'd1024, 32'h77, 3, 1'b1);
    rd(32'd1024, 3);
    chk("both_rdata", 64'(last_rd), 64'h77);
    rd(32'd16, 2);
    chk("wrap_rdata", 64'(last_rd), 64'hC00C_0002);
    chk("miss_count4", 64'(miss_count), 64'd4);
    idle(1);

    // Abandon a read miss two cycles in.
    $display("reset during read miss addr=%h", 32'd1032);
    sram_lat  = 5;
    cur_addr  = 32'd1032;
    cur_wdata = wdata;
    mk(1'b0, 32'h0, 0, 0, 0, 0, 0);
    m_misses = m_misses + 1;
    mk(1'b0, 32'h0, 0, 0, 0, 1, 0);
    address  = 32'd1032;
    mem_r_en = 1'b1;
    run(2);
    check_en = 1'b0;
    rst      = 1'b0;
    mem_r_en = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_sr",    64'(sram_r_en), 64'd0);
    chk("arst_strb",  64'({cache_writeEn, cache_invalidate, cache_LRU_update}), 64'd0);
    chk("arst_miss",  64'(miss_count), 64'd0);
    chk("arst_hit",   64'(hit_count), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    m_hits   = 0;
    m_misses = 0;
    check_en = 1'b1;
    idle(1);

    for (int i = 0; i < 5; i++) rd((i % 2 == 0) ? 32'd1024 : 32'd1028, 4);
    chk("sat_hit16", 64'(hit_count), 64'd5);
    chk("sat_hit2",  64'(d2_hit_count), 64'd3);
    idle(2);
    if (q.size() != 0) chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
